// File: rtl/cpu_debug_run_ctrl.sv
// rtl/cpu_debug_run_ctrl.sv - run/step/breakpoint sequencer producing CPU clock-enable pulses
module cpu_debug_run_ctrl #(
    parameter int p_address_width = 10,
    parameter int p_divisor       = 4,
    parameter int p_no_cycles     = 1,
    parameter int p_sync_stages   = 2
) (
    input  logic                       i_w_clk,
    input  logic                       i_w_reset,
    input  logic                       i_w_step,
    input  logic                       i_w_run,
    input  logic                       i_w_halt,
    input  logic                       i_w_bp_en,
    input  logic [p_address_width-1:0] i_w_bp_addr,
    input  logic [p_address_width-1:0] i_w_pc,
    output logic                       o_w_cpu_ce,
    output logic [1:0]                 o_w_state,
    output logic                       o_w_bp_hit,
    output logic [15:0]                o_w_step_count
);

    localparam int lp_presc_w = (p_divisor > 1) ? $clog2(p_divisor) : 1;
    localparam int lp_cnt_w   = $clog2(p_no_cycles + 1);
    localparam logic [lp_presc_w-1:0] lp_presc_max = lp_presc_w'(p_divisor - 1);
    localparam logic [lp_cnt_w-1:0]   lp_cnt_load  = lp_cnt_w'(p_no_cycles);

    typedef enum logic [1:0] {
        S_HALT  = 2'd0,
        S_STEP  = 2'd1,
        S_RUN   = 2'd2,
        S_BREAK = 2'd3
    } state_t;

    state_t                   r_state;
    state_t                   w_next_state;
    logic [p_sync_stages-1:0] r_sync_step;
    logic [p_sync_stages-1:0] r_sync_run;
    logic [p_sync_stages-1:0] r_sync_halt;
    logic                     r_prev_step;
    logic                     r_prev_run;
    logic                     r_prev_halt;
    logic [lp_presc_w-1:0]    r_presc;
    logic [lp_presc_w-1:0]    w_presc_next;
    logic [lp_cnt_w-1:0]      r_pulses;
    logic [lp_cnt_w-1:0]      w_pulses_next;
    logic                     r_skip_bp;
    logic                     w_skip_next;
    logic                     r_ce;
    logic                     w_pulse;
    logic [15:0]              r_step_count;
    logic                     w_ev_step;
    logic                     w_ev_run;
    logic                     w_ev_halt;
    logic                     w_tick;
    logic                     w_bp_match;

    // Button synchronisers plus one delayed copy of each for rising-edge detection
    always_ff @(posedge i_w_clk or negedge i_w_reset) begin
        if (!i_w_reset) begin
            r_sync_step <= '0;
            r_sync_run  <= '0;
            r_sync_halt <= '0;
            r_prev_step <= 1'b0;
            r_prev_run  <= 1'b0;
            r_prev_halt <= 1'b0;
        end else begin
            r_sync_step <= {r_sync_step[p_sync_stages-2:0], i_w_step};
            r_sync_run  <= {r_sync_run[p_sync_stages-2:0], i_w_run};
            r_sync_halt <= {r_sync_halt[p_sync_stages-2:0], i_w_halt};
            r_prev_step <= r_sync_step[p_sync_stages-1];
            r_prev_run  <= r_sync_run[p_sync_stages-1];
            r_prev_halt <= r_sync_halt[p_sync_stages-1];
        end
    end

    assign w_ev_step  = r_sync_step[p_sync_stages-1] & ~r_prev_step;
    assign w_ev_run   = r_sync_run[p_sync_stages-1] & ~r_prev_run;
    assign w_ev_halt  = r_sync_halt[p_sync_stages-1] & ~r_prev_halt;
    assign w_tick     = (r_presc == lp_presc_max);
    // skip_bp lets a fresh RUN leave a PC that already sits on the breakpoint
    assign w_bp_match = i_w_bp_en && (i_w_pc == i_w_bp_addr) && !r_skip_bp;

    // State, prescaler, pulse budget and registered clock-enable
    always_ff @(posedge i_w_clk or negedge i_w_reset) begin
        if (!i_w_reset) begin
            r_state      <= S_HALT;
            r_presc      <= '0;
            r_pulses     <= '0;
            r_skip_bp    <= 1'b0;
            r_ce         <= 1'b0;
            r_step_count <= '0;
        end else begin
            r_state      <= w_next_state;
            r_presc      <= w_presc_next;
            r_pulses     <= w_pulses_next;
            r_skip_bp    <= w_skip_next;
            r_ce         <= w_pulse;
            r_step_count <= r_step_count + 16'(r_ce);
        end
    end

    // Next-state and pulse decision; halt outranks step, step outranks run
    always_comb begin
        w_next_state  = r_state;
        w_pulse       = 1'b0;
        w_pulses_next = r_pulses;
        w_skip_next   = r_skip_bp;
        w_presc_next  = '0;
        case (r_state)
            S_HALT, S_BREAK: begin
                if (w_ev_halt) begin
                    w_next_state = S_HALT;
                end else if (w_ev_step) begin
                    w_next_state  = S_STEP;
                    w_pulses_next = lp_cnt_load;
                end else if (w_ev_run) begin
                    w_next_state = S_RUN;
                    w_skip_next  = 1'b1;
                end
            end
            S_STEP: begin
                if (w_ev_halt || (r_pulses == '0)) begin
                    w_next_state = S_HALT;
                end else if (w_tick) begin
                    w_pulse       = 1'b1;
                    w_pulses_next = r_pulses - lp_cnt_w'(1);
                end
            end
            S_RUN: begin
                if (w_ev_halt) begin
                    w_next_state = S_HALT;
                end else if (w_tick) begin
                    if (w_bp_match) begin
                        w_next_state = S_BREAK;
                    end else begin
                        w_pulse     = 1'b1;
                        w_skip_next = 1'b0;
                    end
                end
            end
            default: w_next_state = S_HALT;
        endcase
        // Prescaler restarts on every state entry and idles at zero outside STEP/RUN
        if ((w_next_state == r_state) && ((r_state == S_STEP) || (r_state == S_RUN)) && !w_tick) begin
            w_presc_next = r_presc + lp_presc_w'(1);
        end
    end

    assign o_w_cpu_ce     = r_ce;
    assign o_w_state      = r_state;
    assign o_w_bp_hit     = (r_state == S_BREAK);
    assign o_w_step_count = r_step_count;

endmodule
